// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first subtractor computing
// D = A - B - Bin over WIDTH cycles with a single full-subtractor cell.
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN enables the signed
// overflow flag V. When the macro is undefined, V is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, next_state;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_bit, b_bit, d_bit, borrow_next;

  // Full-subtractor cell working on the current LSBs and the stored borrow.
  assign a_bit       = a_sr[0];
  assign b_bit       = b_sr[0];
  assign d_bit       = a_bit ^ b_bit ^ borrow;
  assign borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);

  assign last_bit = (state == SHIFT) && (cnt == LAST);
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  // State register; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all flops update
    // from pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and start acceptance (start is ignored while shifting).
  always_comb begin
    // NOTE: defaults come first so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand shift registers, borrow flop, bit counter and result shifter.
  always_ff @(posedge clk) begin
    // NOTE: these registers are small, so they are reset along with the
    // control state; a real memory array would not be reset this way.
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= B;
      res_sr <= '0;
      borrow <= Bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      borrow <= borrow_next;
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

  // Visible results change only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      D    <= '0;
      Bout <= 1'b0;
    end else if (last_bit) begin
      D    <= {d_bit, res_sr[WIDTH-1:1]};
      Bout <= borrow_next;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic a_msb, b_msb;

  // Capture operand sign bits at start; V follows D on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      V     <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= A[WIDTH-1];
        b_msb <= B[WIDTH-1];
      end
      if (last_bit) V <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
    end
  end
`else
  assign V = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors,
// ignored/back-to-back starts, reset mid-operation and random operands.
module tb_serial_subtractor;

  localparam int W = 8;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, v;
  logic [W-1:0] d;

  int n_pass  = 0;
  int n_total = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (a),
    .B    (b),
    .Bin  (bin),
    .busy (busy),
    .done (done),
    .D    (d),
    .Bout (bout),
    .V    (v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present operands with start for exactly one cycle; returns on the
  // falling edge after the accepting rising edge.
  task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini);
    @(negedge clk);
    a = ai; b = bi; bin = bini; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting busy cycles. Optionally pulses start
  // with new operands at a given busy cycle to show it is ignored.
  task automatic wait_done(input int inject_at, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      if (cycles == inject_at) begin
        a = ia; b = ib; bin = 1'b0; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic bini, input logic [W-1:0] ed, input logic eb, input logic ev);
    int cyc, bc;
    launch(ai, bi, bini);
    wait_done(-1, '0, '0, cyc, bc);
    check({tag, "_lat"},  cyc,  8);
    check({tag, "_busy"}, bc,   8);
    check({tag, "_d"},    d,    ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_v"},    v,    ev);
  endtask

  initial begin
    int cyc, bc, dones;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d",    d,    0);
    check("rst_bout", bout, 0);
    check("rst_v",    v,    0);
    rst = 1'b0;

    // Basic and boundary vectors.
    op_check("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    @(negedge clk);
    check("pulse_single", done, 0);
    check("hold_d", d, 8'h1E);
    op_check("under",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op_check("ovf",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OVF);
    op_check("bin_z",  8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    op_check("bin_b",  8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Start during busy is ignored; start during done runs back-to-back.
    launch(8'h33, 8'h11, 1'b0);
    wait_done(3, 8'hFF, 8'h00, cyc, bc);
    check("ign_lat", cyc, 8);
    check("ign_d",   d,   8'h22);
    a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_low", done, 0);
    check("b2b_busy",     busy, 1);
    check("b2b_hold_d",   d,    8'h22);
    wait_done(-1, '0, '0, cyc, bc);
    check("b2b_lat", cyc, 8);
    check("b2b_d",   d,   8'h05);

    // Reset mid-operation discards the result.
    launch(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_d",    d,    0);
    check("mid_rst_bout", bout, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_rst_no_done", dones, 0);

    // Reset and start together: reset wins, start dropped.
    a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_start_busy", busy, 0);
    @(negedge clk);
    check("rst_start_idle", busy, 0);

    // Random operands against an unsigned 9-bit reference.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      logic [W:0]   ref_r;
      logic         ref_v;
      ra    = W'($urandom);
      rb    = W'($urandom);
      rbin  = 1'($urandom);
      ref_r = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      ref_v = OVF & (ra[W-1] ^ rb[W-1]) & (ra[W-1] ^ ref_r[W-1]);
      launch(ra, rb, rbin);
      wait_done(-1, '0, '0, cyc, bc);
      check("rnd_lat",  cyc,  8);
      check("rnd_d",    d,    ref_r[W-1:0]);
      check("rnd_bout", bout, ref_r[W]);
      check("rnd_v",    v,    ref_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
